// File: rtl/wb_arbiter_if.sv
// Write-back bus between the execute/load units and the register-file write port.
// Producers use the master modport; the arbiter uses the slave modport.
interface wb_arbiter_if #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              alu_valid;
  logic [4:0]        alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              ld_valid;
  logic [4:0]        ld_rd;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;
  logic              reg_wr;
  logic [4:0]        wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [CW-1:0]     q_count;
  logic              overflow;

  modport master (
    output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
    input  ld_ready, reg_wr, wr_addr, wr_data, q_count, overflow
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
    output ld_ready, reg_wr, wr_addr, wr_data, q_count, overflow
  );
endinterface

// File: rtl/wb_arbiter.sv
// Single-port register-file write-back arbiter: ALU results win, loads wait in
// an in-order queue, and ALU writes squash older queued/same-cycle loads to the same rd.
module wb_arbiter #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input logic         clk,
  input logic         rst,
  wb_arbiter_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [4:0]        q_rd   [DEPTH];
  logic [DATA_W-1:0] q_data [DEPTH];
  logic [DEPTH-1:0]  q_live;
  logic [AW-1:0]     wptr, rptr;
  logic [CW-1:0]     count;
  logic              ovf;

  logic              reg_wr_p1;
  logic [4:0]        wr_addr_p1;
  logic [DATA_W-1:0] wr_data_p1;

  logic              ld_ready_p0, ld_acc_p0, ld_kill_p0;
  logic              alu_sel_p0, deq_p0, bypass_p0, enq_p0;
  logic              reg_wr_p0;
  logic [4:0]        wr_addr_p0;
  logic [DATA_W-1:0] wr_data_p0;

  // Stage p0: select this cycle's write from registered queue state
  always_comb begin
    ld_ready_p0 = (count < FULL);
    ld_acc_p0   = bus.ld_valid && ld_ready_p0;
    alu_sel_p0  = bus.alu_valid && (bus.alu_rd != 5'd0);
    // A load to x0, or one overtaken by a same-cycle ALU write to its rd, is dropped
    ld_kill_p0  = (bus.ld_rd == 5'd0) || (alu_sel_p0 && (bus.ld_rd == bus.alu_rd));
    deq_p0      = !alu_sel_p0 && (count != '0);
    bypass_p0   = ld_acc_p0 && !ld_kill_p0 && !alu_sel_p0 && (count == '0);
    enq_p0      = ld_acc_p0 && !ld_kill_p0 && !bypass_p0;

    reg_wr_p0  = 1'b0;
    wr_addr_p0 = '0;
    wr_data_p0 = '0;
    if (alu_sel_p0) begin
      reg_wr_p0  = 1'b1;
      wr_addr_p0 = bus.alu_rd;
      wr_data_p0 = bus.alu_data;
    end else if (deq_p0) begin
      // A squashed head still leaves the queue, just without a write
      if (q_live[rptr]) begin
        reg_wr_p0  = 1'b1;
        wr_addr_p0 = q_rd[rptr];
        wr_data_p0 = q_data[rptr];
      end
    end else if (bypass_p0) begin
      reg_wr_p0  = 1'b1;
      wr_addr_p0 = bus.ld_rd;
      wr_data_p0 = bus.ld_data;
    end
  end

  // Stage p1: registered write port and queue bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_wr_p1  <= 1'b0;
      wr_addr_p1 <= '0;
      wr_data_p1 <= '0;
      q_live     <= '0;
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      ovf        <= 1'b0;
    end else begin
      reg_wr_p1  <= reg_wr_p0;
      wr_addr_p1 <= wr_addr_p0;
      wr_data_p1 <= wr_data_p0;

      for (int i = 0; i < DEPTH; i++) begin
        if (alu_sel_p0 && (q_rd[i] == bus.alu_rd)) q_live[i] <= 1'b0;
      end
      if (enq_p0) begin
        q_live[wptr] <= 1'b1;
        wptr         <= wptr + 1'b1;
      end
      if (deq_p0) rptr <= rptr + 1'b1;

      case ({enq_p0, deq_p0})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (bus.ld_valid && !ld_ready_p0) ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && enq_p0) begin
      q_rd[wptr]   <= bus.ld_rd;
      q_data[wptr] <= bus.ld_data;
    end
  end

  assign bus.ld_ready = ld_ready_p0;
  assign bus.reg_wr   = reg_wr_p1;
  assign bus.wr_addr  = wr_addr_p1;
  assign bus.wr_data  = wr_data_p1;
  assign bus.q_count  = count;
  assign bus.overflow = ovf;
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed stimulus pushes expected register writes into a
// scoreboard queue; a negedge monitor pops and compares every write the DUT issues.
module tb_wb_arbiter;
  logic clk;
  logic rst;
  logic mon_en;
  int   n_checks;
  int   n_pass;
  logic [36:0] exp_q [$];

  wb_arbiter_if #(.DEPTH(4), .DATA_W(32)) bus ();

  wb_arbiter #(.DEPTH(4), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ldat);
    bus.alu_valid = av;
    bus.alu_rd    = ard;
    bus.alu_data  = ad;
    bus.ld_valid  = lv;
    bus.ld_rd     = lrd;
    bus.ld_data   = ldat;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.reg_wr) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_write: got x%0d=%0h, expected no write", bus.wr_addr, bus.wr_data);
        end else begin
          logic [36:0] e;
          e = exp_q.pop_front();
          chk("wr_addr", 64'(bus.wr_addr), 64'(e[36:32]));
          chk("wr_data", 64'(bus.wr_data), 64'(e[31:0]));
        end
      end else begin
        chk("idle_outputs_zero", 64'({bus.wr_addr, bus.wr_data}), 64'h0);
      end
    end
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    mon_en   = 1'b0;
    rst      = 1'b1;
    idle();
    repeat (2) step();

    chk("rst_reg_wr",   64'(bus.reg_wr),   64'h0);
    chk("rst_wr_addr",  64'(bus.wr_addr),  64'h0);
    chk("rst_wr_data",  64'(bus.wr_data),  64'h0);
    chk("rst_q_count",  64'(bus.q_count),  64'h0);
    chk("rst_overflow", 64'(bus.overflow), 64'h0);
    chk("rst_ld_ready", 64'(bus.ld_ready), 64'h1);
    rst    = 1'b0;
    mon_en = 1'b1;

    // Single ALU write, one-cycle latency, then idle
    expect_wr(5'd5, 32'h1234);
    drive(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'h0);
    step();
    chk("alu_latency_reg_wr", 64'(bus.reg_wr), 64'h1);
    idle();
    step();
    chk("alu_then_idle", 64'(bus.reg_wr), 64'h0);

    // ALU and load in the same cycle: load waits one entry in the queue
    expect_wr(5'd3, 32'hA);
    expect_wr(5'd4, 32'hB);
    drive(1'b1, 5'd3, 32'hA, 1'b1, 5'd4, 32'hB);
    step();
    chk("same_cycle_q1", 64'(bus.q_count), 64'h1);
    idle();
    step();
    chk("same_cycle_q0", 64'(bus.q_count), 64'h0);
    step();

    // Continuous ALU traffic while five loads arrive: fifth overflows
    for (int i = 0; i < 5; i++) begin
      chk("fill_ld_ready", 64'(bus.ld_ready), (i < 4) ? 64'h1 : 64'h0);
      expect_wr(5'(20 + i), 32'h100 + 32'(i));
      drive(1'b1, 5'(20 + i), 32'h100 + 32'(i), 1'b1, 5'(11 + i), 32'h200 + 32'(i));
      step();
    end
    chk("full_overflow", 64'(bus.overflow), 64'h1);
    chk("full_q_count",  64'(bus.q_count),  64'h4);
    chk("full_ld_ready", 64'(bus.ld_ready), 64'h0);
    for (int j = 0; j < 4; j++) expect_wr(5'(11 + j), 32'h200 + 32'(j));
    idle();
    repeat (4) step();
    chk("drain_q_count",  64'(bus.q_count),  64'h0);
    chk("drain_ld_ready", 64'(bus.ld_ready), 64'h1);
    step();

    // Queued x7 load is squashed by a younger ALU write to x7
    expect_wr(5'd9, 32'h99);
    drive(1'b1, 5'd9, 32'h99, 1'b1, 5'd7, 32'h77);
    step();
    expect_wr(5'd7, 32'h55);
    drive(1'b1, 5'd7, 32'h55, 1'b0, 5'd0, 32'h0);
    step();
    chk("squash_q1", 64'(bus.q_count), 64'h1);
    idle();
    step();
    chk("squash_q0",     64'(bus.q_count), 64'h0);
    chk("squash_no_wr",  64'(bus.reg_wr),  64'h0);
    repeat (2) step();

    // x0 destinations are discarded
    drive(1'b1, 5'd0, 32'h111, 1'b1, 5'd0, 32'h222);
    step();
    chk("rd0_q_count", 64'(bus.q_count), 64'h0);
    chk("rd0_reg_wr",  64'(bus.reg_wr),  64'h0);
    // ALU to x0 does not block an empty-queue load bypass
    expect_wr(5'd6, 32'h66);
    drive(1'b1, 5'd0, 32'h111, 1'b1, 5'd6, 32'h66);
    step();
    chk("bypass_q_count", 64'(bus.q_count), 64'h0);
    chk("bypass_reg_wr",  64'(bus.reg_wr),  64'h1);
    idle();
    step();

    // Reset mid-operation with three queued loads
    chk("pre_rst_overflow", 64'(bus.overflow), 64'h1);
    for (int i = 0; i < 3; i++) begin
      expect_wr(5'(17 + i), 32'h300 + 32'(i));
      drive(1'b1, 5'(17 + i), 32'h300 + 32'(i), 1'b1, 5'(1 + i), 32'h400 + 32'(i));
      step();
    end
    chk("pre_rst_q_count", 64'(bus.q_count), 64'h3);
    rst = 1'b1;
    drive(1'b1, 5'd25, 32'hDEAD, 1'b1, 5'd26, 32'hBEEF);
    step();
    chk("mid_rst_q_count",  64'(bus.q_count),  64'h0);
    chk("mid_rst_overflow", 64'(bus.overflow), 64'h0);
    chk("mid_rst_reg_wr",   64'(bus.reg_wr),   64'h0);
    chk("mid_rst_wr_addr",  64'(bus.wr_addr),  64'h0);
    rst = 1'b0;
    idle();
    step();
    chk("post_rst_reg_wr",   64'(bus.reg_wr),   64'h0);
    chk("post_rst_ld_ready", 64'(bus.ld_ready), 64'h1);
    repeat (6) step();

    chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter: DEPTH, 4, number of load-result queue entries (power of 2, 2..16).
REQ-002 SHALL have port: clk  input  1  clock; all state updates on posedge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: alu_valid  input  1  ALU result present this cycle.
REQ-005 SHALL have port: alu_rd  input  5  ALU destination register.
REQ-006 SHALL have port: alu_data  input  32  ALU result.
REQ-007 SHALL have port: ld_valid  input  1  load result present this cycle.
REQ-008 SHALL have port: ld_rd  input  5  load destination register.
REQ-009 SHALL have port: ld_data  input  32  load data from DMEM.
REQ-010 SHALL have port: ld_ready  output  1  load result acceptable this cycle.
REQ-011 SHALL have port: reg_wr  output  1  register-file write enable.
REQ-012 SHALL have port: wr_addr  output  5  register-file write address (rd).
REQ-013 SHALL have port: wr_data  output  32  register-file write data.
REQ-014 SHALL have port: q_count  output  log2(DEPTH)+1  queued load entries.
REQ-015 SHALL have port: overflow  output  1  sticky flag, load dropped while not ready.

Function
REQ-016 SHALL register reg_wr/wr_addr/wr_data on posedge clk, so they are stable for the register file's negedge write in the same cycle.
REQ-017 SHALL select at most one write per cycle with priority: (1) ALU if alu_valid and alu_rd!=0; (2) queue head if q_count>0; (3) incoming load (bypass) if accepted, ld_rd!=0, queue empty.
REQ-018 SHALL give latency 1 cycle from ALU/bypass input to reg_wr=1 at the output.
REQ-019 SHALL accept a load only when ld_valid and ld_ready; ld_ready = (q_count < DEPTH), derived from registered count only.
REQ-020 SHALL enqueue an accepted load with ld_rd!=0 whenever it is not bypassed (ALU wins or queue non-empty).
REQ-021 SHALL write queued loads strictly in arrival order; enqueue and dequeue in the same cycle SHALL leave q_count unchanged.
REQ-022 SHALL discard any result with rd=0 (never queued, never written); reg_wr=1 with wr_addr=0 SHALL never occur.
REQ-023 SHALL treat ALU results as younger than any queued or same-cycle load: on an ALU write to rd=R, every queued entry with rd=R is squashed (removed at dequeue without reg_wr), and a same-cycle accepted load with ld_rd=R is dropped.
REQ-024 SHALL, when the head is squashed, dequeue it with no write in that cycle; the next live entry is eligible the following cycle.
REQ-025 SHALL drive reg_wr=0, wr_addr=0, wr_data=0 in any cycle with no selected write.
REQ-026 SHALL set overflow=1 on ld_valid=1 with ld_ready=0, drop that load, and hold overflow until reset.
REQ-027 SHALL wrap queue read/write pointers modulo DEPTH; q_count SHALL never exceed DEPTH or go below 0.

Reset
REQ-028 SHALL, while rst=1 at posedge: reg_wr=0, wr_addr=0, wr_data=0, q_count=0, overflow=0, pointers=0, all entries invalid; ld_ready=1 thereafter.
REQ-029 SHALL discard all queued entries on reset asserted mid-operation; no write SHALL issue in the cycle following reset.
REQ-030 SHALL ignore alu_valid/ld_valid in cycles where rst=1.

Verification
REQ-031 SHALL test: alu_valid=1, alu_rd=5, alu_data=0x1234 -> next cycle reg_wr=1, wr_addr=5, wr_data=0x1234; then reg_wr=0.
REQ-032 SHALL test: same cycle ALU(rd=3,0xA) and load(rd=4,0xB) -> cycle+1 writes x3=0xA, cycle+2 writes x4=0xB, q_count 1 then 0.
REQ-033 SHALL test: ALU every cycle while 5 loads arrive (DEPTH=4) -> ld_ready=0 after 4th, 5th dropped, overflow=1; after ALU stops, loads 1-4 written in order.
REQ-034 SHALL test: queue holds load rd=7 then ALU writes rd=7=0x55 -> x7 written once with 0x55; queued entry squashed, q_count reaches 0 with no further write.
REQ-035 SHALL test: ALU rd=0 and load rd=0 -> reg_wr stays 0, q_count stays 0.
REQ-036 SHALL test: rst pulsed with q_count=3 -> q_count=0, overflow=0, reg_wr=0 next cycle; no stale entries ever written.
